// File: rtl/synth_pkg.sv
// Shared constants and types for the synth keyboard front end.
// The debounce default is derived from the clock so that it stays near 1 ms.
package synth_pkg;

    localparam int NUM_KEYS         = 12;
    localparam int CLK_HZ           = 3_028_000;
    localparam int DEBOUNCE_DEFAULT = CLK_HZ / 1000;

    typedef logic [3:0] key_idx_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/key_debouncer.sv
// One key front end: 2-flop synchronizer, stability counter and stable level.
// Press/release pulses are combinational and coincide with the edge on which the stable level flips.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = synth_pkg::DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_flip;

    assign w_differ = (r_sync2 != r_stable);
    // The flip edge is the DEBOUNCE_CYCLES-th consecutive edge seeing a difference.
    assign w_flip   = w_differ && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press   = w_flip && !r_stable;
    assign o_release = w_flip &&  r_stable;

endmodule

// File: rtl/key_priority_scheduler.sv
// Last-note-priority key arbiter: per-key debounce, pending event flags, a press-order
// stack serviced one event per cycle, and registered one-hot/gate/strobe outputs.
module key_priority_scheduler
    import synth_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic [3:0]          note_idx,
    output logic                gate,
    output logic                note_change,
    output logic                dbg_state
);

    localparam logic [NUM_KEYS-1:0] ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] r_press_flag;
    logic [NUM_KEYS-1:0] r_release_flag;
    logic [NUM_KEYS-1:0] w_press_flag_next;
    logic [NUM_KEYS-1:0] w_release_flag_next;

    sched_state_t r_state;
    sched_state_t w_state_next;

    logic                w_svc_valid;
    logic                w_svc_is_rel;
    key_idx_t            w_svc_idx;
    logic [NUM_KEYS-1:0] w_svc_mask;

    key_idx_t            r_stack [NUM_KEYS];
    key_idx_t            w_stack_next [NUM_KEYS];
    logic [3:0]          r_count;
    logic [3:0]          w_count_next;
    logic [NUM_KEYS-1:0] w_match;
    logic                w_found;
    logic                w_seen;

    logic [NUM_KEYS-1:0] r_key_onehot;
    logic [3:0]          r_note_idx;
    logic                r_gate;
    logic                r_note_change;
    logic                w_gate_next;
    logic [3:0]          w_note_next;
    logic [NUM_KEYS-1:0] w_onehot_next;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (keys_raw[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    // Event selection: releases outrank presses, lowest index first within a class.
    always_comb begin
        w_svc_valid  = 1'b0;
        w_svc_is_rel = 1'b0;
        w_svc_idx    = '0;
        if (r_state == ST_SERVICE) begin
            if (|r_release_flag) begin
                w_svc_valid  = 1'b1;
                w_svc_is_rel = 1'b1;
                for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                    if (r_release_flag[i]) w_svc_idx = key_idx_t'(i);
                end
            end else if (|r_press_flag) begin
                w_svc_valid = 1'b1;
                for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                    if (r_press_flag[i]) w_svc_idx = key_idx_t'(i);
                end
            end
        end
    end

    always_comb begin
        w_svc_mask          = w_svc_valid ? (ONE << w_svc_idx) : '0;
        w_press_flag_next   = (r_press_flag   & ~(w_svc_is_rel ? '0 : w_svc_mask)) | w_press;
        w_release_flag_next = (r_release_flag & ~(w_svc_is_rel ? w_svc_mask : '0)) | w_release;
        w_state_next        = (|w_press_flag_next || |w_release_flag_next) ? ST_SERVICE : ST_IDLE;
    end

    // Stack update: push on top, or close the gap left by the released entry.
    always_comb begin
        w_stack_next = r_stack;
        w_count_next = r_count;
        w_match      = '0;
        w_found      = 1'b0;
        w_seen       = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_match[i] = (4'(i) < r_count) && (r_stack[i] == w_svc_idx);
        end
        w_found = |w_match;
        if (w_svc_valid && !w_svc_is_rel) begin
            w_stack_next[r_count] = w_svc_idx;
            w_count_next          = r_count + 4'd1;
        end else if (w_svc_valid && w_found) begin
            for (int i = 0; i < NUM_KEYS - 1; i++) begin
                w_seen = w_seen | w_match[i];
                if (w_seen) w_stack_next[i] = r_stack[i+1];
            end
            w_count_next = r_count - 4'd1;
        end
    end

    always_comb begin
        w_gate_next   = (r_count != 4'd0);
        w_note_next   = w_gate_next ? r_stack[r_count - 4'd1] : r_note_idx;
        w_onehot_next = w_gate_next ? (ONE << w_note_next) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_press_flag   <= '0;
            r_release_flag <= '0;
            r_count        <= '0;
            for (int i = 0; i < NUM_KEYS; i++) r_stack[i] <= '0;
            r_key_onehot   <= '0;
            r_note_idx     <= '0;
            r_gate         <= 1'b0;
            r_note_change  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_press_flag   <= w_press_flag_next;
            r_release_flag <= w_release_flag_next;
            r_count        <= w_count_next;
            r_stack        <= w_stack_next;
            r_key_onehot   <= w_onehot_next;
            r_note_idx     <= w_note_next;
            r_gate         <= w_gate_next;
            r_note_change  <= (w_onehot_next != r_key_onehot);
        end
    end

    // A release for a key absent from the stack means the flag bookkeeping is broken.
    always @(posedge clk) begin
        if (!rst && w_svc_valid && w_svc_is_rel) begin
            assert (w_found);
        end
    end

    assign key_onehot  = r_key_onehot;
    assign note_idx    = r_note_idx;
    assign gate        = r_gate;
    assign note_change = r_note_change;
    assign dbg_state   = r_state;

endmodule
